// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes, multiplier register map and master state encoding
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   localparam logic [7:0] REG_A      = 8'h00;
   localparam logic [7:0] REG_B      = 8'h04;
   localparam logic [7:0] REG_CTRL   = 8'h08;
   localparam logic [7:0] REG_STATUS = 8'h0C;
   localparam logic [7:0] REG_RES_LO = 8'h10;
   localparam logic [7:0] REG_RES_HI = 8'h14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_A,
      ST_WR_B,
      ST_WR_CTRL,
      ST_POLL,
      ST_RD_LO,
      ST_RD_HI,
      ST_RESP
   } mst_state_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != OKAY;
   endfunction

endpackage

// File: rtl/axi4_lite_master_port.sv
// rtl/axi4_lite_master_port.sv - single-transaction AXI4-Lite engine: one write (AW+W+B) or one read (AR+R) in flight
module axi4_lite_master_port #(
   parameter int SZ     = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              _rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [SZ-1:0]     req_wdata,
   output logic              req_done,
   output logic [1:0]        req_resp,
   output logic [SZ-1:0]     req_rdata,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awaddr,
   input  logic              awready,
   output logic              wvalid,
   output logic [SZ-1:0]     wdata,
   output logic [SZ/8-1:0]   wstrb,
   input  logic              wready,
   input  logic              bvalid,
   input  logic [1:0]        bresp,
   output logic              bready,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [SZ-1:0]     rdata,
   input  logic [1:0]        rresp,
   output logic              rready
);

   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [SZ-1:0]     wdata_q, wdata_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, busy;

   assign aw_hs = awvalid_q && awready;
   assign w_hs  = wvalid_q && wready;
   assign b_hs  = bready_q && bvalid;
   assign ar_hs = arvalid_q && arready;
   assign r_hs  = rready_q && rvalid;
   assign busy  = awvalid_q || wvalid_q || aw_done_q || w_done_q || bready_q ||
                  arvalid_q || rready_q;

   always_comb begin
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;

      if (req_valid && !busy) begin
         if (req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
         end else begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
         end
      end

      // AW and W complete independently; B is only accepted once both are done
      if (aw_hs) begin
         awvalid_d = 1'b0;
         aw_done_d = 1'b1;
      end
      if (w_hs) begin
         wvalid_d = 1'b0;
         w_done_d = 1'b1;
      end
      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
         bready_d  = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
      if (b_hs) begin
         bready_d = 1'b0;
      end

      if (ar_hs) begin
         arvalid_d = 1'b0;
         rready_d  = 1'b1;
      end
      if (r_hs) begin
         rready_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (_rst) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
      end else begin
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign awvalid   = awvalid_q;
   assign awaddr    = awaddr_q;
   assign wvalid    = wvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = '1;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign araddr    = araddr_q;
   assign rready    = rready_q;
   assign req_done  = b_hs || r_hs;
   assign req_resp  = b_hs ? bresp : rresp;
   assign req_rdata = rdata;

endmodule

// File: rtl/axi4_lite_mult_master.sv
// rtl/axi4_lite_mult_master.sv - AXI4-Lite master sequencing a multiplier slave
// Optional STATUS poll limit compiled in with AXI_MASTER_TIMEOUT_EN.
module axi4_lite_mult_master
   import axi4_lite_pkg::*;
#(
   parameter int SZ       = 32,
   parameter int ADDR_W   = 8,
   parameter int POLL_MAX = 1024
) (
   input  logic              clk,
   input  logic              _rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SZ-1:0]     cmd_a,
   input  logic [SZ-1:0]     cmd_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2*SZ-1:0]   rsp_res,
   output logic              rsp_err,
   output logic              awvalid,
   output logic [ADDR_W-1:0] awaddr,
   input  logic              awready,
   output logic              wvalid,
   output logic [SZ-1:0]     wdata,
   output logic [SZ/8-1:0]   wstrb,
   input  logic              wready,
   input  logic              bvalid,
   input  logic [1:0]        bresp,
   output logic              bready,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [SZ-1:0]     rdata,
   input  logic [1:0]        rresp,
   output logic              rready
);

   mst_state_t      state_q, state_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [2*SZ-1:0] rsp_res_q, rsp_res_d;
   logic [SZ-1:0]   a_q, a_d;
   logic [SZ-1:0]   b_q, b_d;
   logic            issued_q, issued_d;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int PCNT_W = $clog2(POLL_MAX + 1);
   logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
`else
   logic unused_poll_max;
   assign unused_poll_max = (POLL_MAX > 0);
`endif

   logic              req_valid, req_write, req_done, xact_state;
   logic [ADDR_W-1:0] req_addr;
   logic [SZ-1:0]     req_wdata, req_rdata;
   logic [1:0]        req_resp;

   assign xact_state = (state_q != ST_IDLE) && (state_q != ST_RESP);

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_res_d   = rsp_res_q;
      a_d         = a_q;
      b_d         = b_q;
      issued_d    = issued_q;
`ifdef AXI_MASTER_TIMEOUT_EN
      poll_cnt_d  = poll_cnt_q;
`endif
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               a_d         = cmd_a;
               b_d         = cmd_b;
               rsp_res_d   = '0;
               rsp_err_d   = 1'b0;
               cmd_ready_d = 1'b0;
               issued_d    = 1'b0;
               state_d     = ST_WR_A;
            end
         end
         ST_WR_A: begin
            req_write = 1'b1;
            req_addr  = ADDR_W'(REG_A);
            req_wdata = a_q;
         end
         ST_WR_B: begin
            req_write = 1'b1;
            req_addr  = ADDR_W'(REG_B);
            req_wdata = b_q;
         end
         ST_WR_CTRL: begin
            req_write = 1'b1;
            req_addr  = ADDR_W'(REG_CTRL);
            req_wdata = SZ'(1);
         end
         ST_POLL:  req_addr = ADDR_W'(REG_STATUS);
         ST_RD_LO: req_addr = ADDR_W'(REG_RES_LO);
         ST_RD_HI: req_addr = ADDR_W'(REG_RES_HI);
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Each bus state launches exactly one transaction and waits for its response
      if (xact_state && !issued_q) begin
         req_valid = 1'b1;
         issued_d  = 1'b1;
      end

      if (xact_state && req_done) begin
         issued_d = 1'b0;
         if (resp_is_err(req_resp)) begin
            rsp_res_d   = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end else begin
            case (state_q)
               ST_WR_A:    state_d = ST_WR_B;
               ST_WR_B:    state_d = ST_WR_CTRL;
               ST_WR_CTRL: begin
                  state_d = ST_POLL;
`ifdef AXI_MASTER_TIMEOUT_EN
                  poll_cnt_d = '0;
`endif
               end
               ST_POLL: begin
                  if (req_rdata[0]) begin
                     state_d = ST_RD_LO;
                  end
`ifdef AXI_MASTER_TIMEOUT_EN
                  else if (poll_cnt_q == PCNT_W'(POLL_MAX - 1)) begin
                     rsp_res_d   = '0;
                     rsp_err_d   = 1'b1;
                     rsp_valid_d = 1'b1;
                     state_d     = ST_RESP;
                  end else begin
                     poll_cnt_d = poll_cnt_q + PCNT_W'(1);
                  end
`endif
               end
               ST_RD_LO: begin
                  rsp_res_d[SZ-1:0] = req_rdata;
                  state_d           = ST_RD_HI;
               end
               ST_RD_HI: begin
                  rsp_res_d[2*SZ-1:SZ] = req_rdata;
                  rsp_valid_d          = 1'b1;
                  state_d              = ST_RESP;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (_rst) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_res_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         issued_q    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
         poll_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_res_q   <= rsp_res_d;
         a_q         <= a_d;
         b_q         <= b_d;
         issued_q    <= issued_d;
`ifdef AXI_MASTER_TIMEOUT_EN
         poll_cnt_q  <= poll_cnt_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_res   = rsp_res_q;

   axi4_lite_master_port #(
      .SZ     (SZ),
      .ADDR_W (ADDR_W)
   ) u_port (
      .clk       (clk),
      ._rst      (_rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_resp  (req_resp),
      .req_rdata (req_rdata),
      .awvalid   (awvalid),
      .awaddr    (awaddr),
      .awready   (awready),
      .wvalid    (wvalid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wready    (wready),
      .bvalid    (bvalid),
      .bresp     (bresp),
      .bready    (bready),
      .arvalid   (arvalid),
      .araddr    (araddr),
      .arready   (arready),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rready    (rready)
   );

endmodule

// File: tb/tb_axi4_lite_mult_master.sv
// tb/tb_axi4_lite_mult_master.sv - directed bench for axi4_lite_mult_master with a behavioural multiplier slave
module tb_axi4_lite_mult_master;
   import axi4_lite_pkg::*;

   localparam int TB_POLL_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_res;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [7:0]  awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
   logic        bvalid = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;

   always #5 clk = ~clk;

   axi4_lite_mult_master #(.SZ(32), .ADDR_W(8), .POLL_MAX(TB_POLL_MAX)) dut (
      .clk(clk), ._rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_err(rsp_err),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
   );

   int n_checks = 0;
   int n_err    = 0;

   // slave knobs, written only by the stimulus block
   int         aw_delay = 0;
   int         ready_after = 1;
   int         status_base = 0;
   bit         rand_stall = 1'b0;
   logic [7:0] err_addr = 8'hFF;

   // slave state and logs, written only by the slave process
   int          wr_cnt = 0, st_reads = 0, ctrl_wr = 0, stab_err = 0;
   logic [7:0]  wr_addr_log [64];
   logic [31:0] wr_data_log [64];
   logic [31:0] reg_a = '0, reg_b = '0;
   logic [63:0] prod = '0;
   bit          aw_got, w_got, rpend, hs_aw, hs_w, hs_ar, hs_b, hs_r;
   bit          pend_aw, pend_w, pend_ar;
   int          aw_wait, rdly;
   logic [7:0]  wa, ra, cap_awaddr, cap_araddr;
   logic [31:0] wd, cap_wdata;

   always @(negedge clk) begin
      if (rst) begin
         awready = 1'b0; wready = 1'b0; arready = 1'b0;
         bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
         aw_got = 0; w_got = 0; rpend = 0; aw_wait = 0; rdly = 0;
         hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
         pend_aw = 0; pend_w = 0; pend_ar = 0;
      end else begin
         if (hs_aw) begin aw_got = 1; wa = cap_awaddr; end
         if (hs_w)  begin w_got = 1; wd = cap_wdata; end
         if (hs_b)  bvalid = 1'b0;
         if (hs_r)  rvalid = 1'b0;
         if (hs_ar) begin
            rpend = 1; ra = cap_araddr;
            rdly = rand_stall ? int'($urandom_range(0, 3)) : 0;
         end
         if (aw_got && w_got) begin
            wr_addr_log[wr_cnt % 64] = wa;
            wr_data_log[wr_cnt % 64] = wd;
            wr_cnt++;
            case (wa)
               8'h00: reg_a = wd;
               8'h04: reg_b = wd;
               8'h08: begin
                  ctrl_wr++;
                  if (wd[0]) prod = {32'h0, reg_a} * {32'h0, reg_b};
               end
               default: ;
            endcase
            bvalid = 1'b1;
            bresp = (wa == err_addr) ? SLVERR : OKAY;
            aw_got = 0; w_got = 0;
         end
         if (rpend) begin
            if (rdly > 0) rdly--;
            else begin
               rpend = 0; rvalid = 1'b1; rresp = OKAY;
               case (ra)
                  8'h0C: begin
                     st_reads++;
                     rdata = (ready_after != 0 && (st_reads - status_base) >= ready_after) ? 32'h1 : 32'h0;
                  end
                  8'h10: rdata = prod[31:0];
                  8'h14: rdata = prod[63:32];
                  default: rdata = 32'h0;
               endcase
            end
         end
         // valid must persist with stable payload until its handshake
         if (pend_aw && (!awvalid || awaddr !== cap_awaddr)) stab_err++;
         if (pend_w && (!wvalid || wdata !== cap_wdata)) stab_err++;
         if (pend_ar && (!arvalid || araddr !== cap_araddr)) stab_err++;
         if (wvalid && wstrb !== 4'hF) stab_err++;
         if ((awvalid || wvalid || bready) && (arvalid || rready)) stab_err++;

         if (awvalid && !aw_got) begin
            if (aw_wait >= aw_delay) awready = 1'b1;
            else begin awready = 1'b0; aw_wait++; end
         end else begin
            awready = 1'b0; aw_wait = 0;
         end
         wready = wvalid && !w_got;
         if (arvalid && !rpend && !rvalid) arready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         else arready = 1'b0;

         hs_aw = awvalid && awready; cap_awaddr = awaddr; pend_aw = awvalid && !awready;
         hs_w  = wvalid && wready;   cap_wdata  = wdata;  pend_w  = wvalid && !wready;
         hs_ar = arvalid && arready; cap_araddr = araddr; pend_ar = arvalid && !arready;
         hs_b  = bvalid && bready;
         hs_r  = rvalid && rready;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin step(); n++; end
      chk("cmd_accepted", 64'(n < 50), 64'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input int hold, input logic [63:0] exp_res, input logic exp_err);
      int n = 0;
      rsp_ready = (hold == 0);
      while (!rsp_valid && n < 2000) begin step(); n++; end
      chk({tag, "_rsp_seen"}, 64'(n < 2000), 64'd1);
      chk({tag, "_res"}, rsp_res, exp_res);
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, "_hold_res"}, rsp_res, exp_res);
      end
      rsp_ready = 1'b1;
      step();
      chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int wbase, cbase, n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
      repeat (3) step();
      chk("rst_awvalid", 64'(awvalid), 64'd0);
      chk("rst_wvalid", 64'(wvalid), 64'd0);
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_bready", 64'(bready), 64'd0);
      chk("rst_rready", 64'(rready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_res", rsp_res, 64'd0);
      rst = 1'b0;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // 3 * 5, STATUS ready on the third poll, response held off for two cycles
      ready_after = 3; status_base = st_reads; wbase = wr_cnt;
      send_cmd(32'd3, 32'd5);
      get_rsp("basic", 2, 64'd15, 1'b0);
      chk("basic_wr_cnt", 64'(wr_cnt - wbase), 64'd3);
      chk("basic_addr0", 64'(wr_addr_log[wbase % 64]), 64'h00);
      chk("basic_addr1", 64'(wr_addr_log[(wbase + 1) % 64]), 64'h04);
      chk("basic_addr2", 64'(wr_addr_log[(wbase + 2) % 64]), 64'h08);
      chk("basic_data0", 64'(wr_data_log[wbase % 64]), 64'd3);
      chk("basic_data1", 64'(wr_data_log[(wbase + 1) % 64]), 64'd5);
      chk("basic_data2", 64'(wr_data_log[(wbase + 2) % 64]), 64'd1);
      chk("basic_polls", 64'(st_reads - status_base), 64'd3);

      ready_after = 1; status_base = st_reads;
      send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      get_rsp("maxop", 0, 64'hFFFF_FFFE_0000_0001, 1'b0);

      // AW lags W by four cycles, random AR/R stalls
      aw_delay = 4; rand_stall = 1'b1; ready_after = 2; status_base = st_reads;
      send_cmd(32'h1234, 32'hABCD);
      get_rsp("stall", 0, 64'h0C37_4FA4, 1'b0);
      chk("stall_polls", 64'(st_reads - status_base), 64'd2);
      aw_delay = 0; rand_stall = 1'b0;

      // SLVERR on the B write aborts before CTRL
      err_addr = 8'h04; ready_after = 1; status_base = st_reads;
      wbase = wr_cnt; cbase = ctrl_wr;
      send_cmd(32'd9, 32'd9);
      get_rsp("slverr", 0, 64'd0, 1'b1);
      chk("slverr_wr_cnt", 64'(wr_cnt - wbase), 64'd2);
      chk("slverr_no_ctrl", 64'(ctrl_wr - cbase), 64'd0);
      err_addr = 8'hFF;

      // reset while a STATUS read is outstanding
      ready_after = 0; status_base = st_reads;
      send_cmd(32'd11, 32'd13);
      n = 0;
      while (!arvalid && n < 200) begin step(); n++; end
      chk("poll_arvalid_seen", 64'(n < 200), 64'd1);
      rst = 1'b1;
      step();
      chk("midrst_arvalid", 64'(arvalid), 64'd0);
      chk("midrst_rready", 64'(rready), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      ready_after = 2; status_base = st_reads;
      send_cmd(32'd7, 32'd6);
      get_rsp("after_rst", 0, 64'd42, 1'b0);

`ifdef AXI_MASTER_TIMEOUT_EN
      ready_after = 0; status_base = st_reads;
      send_cmd(32'd2, 32'd3);
      get_rsp("timeout", 0, 64'd0, 1'b1);
      chk("timeout_polls", 64'(st_reads - status_base), 64'(TB_POLL_MAX));
`endif

      chk("bus_protocol_violations", 64'(stab_err), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/axi4_lite_mult_master.md
AXI4_LITE_MULT_MASTER -- requirements
Module: axi4_lite_mult_master

Interface
REQ-001 SHALL have parameter SZ, default 32, operand width and AXI data width.
REQ-002 SHALL have parameter ADDR_W, default 8, AXI address width.
REQ-003 SHALL have parameter POLL_MAX, default 1024, status-poll limit when timeout is compiled in.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 _rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  operand request handshake.
REQ-007 cmd_a, cmd_b  in  SZ each  operands, sampled on cmd handshake.
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-009 rsp_res  out  2*SZ  product; rsp_err  out  1  transaction error flag.
REQ-010 awvalid, awaddr / awready  out, out / in  1, ADDR_W / 1  write-address channel.
REQ-011 wvalid, wdata, wstrb / wready  out / in  1, SZ, SZ/8 / 1  write-data channel.
REQ-012 bvalid, bresp / bready  in / out  1, 2 / 1  write-response channel.
REQ-013 arvalid, araddr / arready  out / in  1, ADDR_W / 1  read-address channel.
REQ-014 rvalid, rdata, rresp / rready  in / out  1, SZ, 2 / 1  read-data channel.

Function
REQ-015 SHALL drive the multiplier slave register map: 0x00 A, 0x04 B, 0x08 CTRL (bit0 start), 0x0C STATUS (bit0 ready), 0x10 RES_LO, 0x14 RES_HI.
REQ-016 SHALL implement FSM IDLE -> WR_A -> WR_B -> WR_CTRL -> POLL -> RD_LO -> RD_HI -> RESP -> IDLE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; handshake latches cmd_a/cmd_b and enters WR_A next cycle.
REQ-018 Each write SHALL assert awvalid and wvalid in the same cycle, drop each independently on its own handshake, hold awaddr/wdata stable until then, and wstrb SHALL be all ones.
REQ-019 bready SHALL be 1 once both AW and W have handshaked; the state advances on the bvalid&&bready cycle.
REQ-020 Each read SHALL hold arvalid and araddr until arready, then assert rready until the rvalid handshake.
REQ-021 No *valid SHALL depend combinationally on any *ready; at most one outstanding transaction at any time.
REQ-022 POLL SHALL read STATUS repeatedly; rdata[0]=1 advances to RD_LO, 0 re-issues the read on the next cycle.
REQ-023 RD_LO SHALL capture rsp_res[SZ-1:0]; RD_HI SHALL capture rsp_res[2*SZ-1:SZ].
REQ-024 Any bresp or rresp != 2'b00 SHALL set rsp_err, abort remaining transactions, and go to RESP; on abort rsp_res is all zeros.
REQ-025 RESP SHALL hold rsp_valid=1 with rsp_res and rsp_err stable until rsp_ready, then return to IDLE; rsp_ready=1 on entry completes in one cycle.
REQ-026 WR_CTRL SHALL write 0x1; the START bit is never cleared by the master.

Reset
REQ-027 When _rst=1 at a clock edge, state SHALL become IDLE and all *valid, bready, rready, rsp_valid, rsp_err, and rsp_res SHALL become 0, including mid-transaction; no in-flight handshake is completed.
REQ-028 After reset, cmd_ready SHALL be 1 on the first cycle with _rst=0.

Configuration
REQ-029 With AXI_MASTER_TIMEOUT_EN defined, the STATUS reads in POLL SHALL be counted; after POLL_MAX reads with ready=0, the block SHALL set rsp_err and enter RESP with rsp_res=0.
REQ-030 Without AXI_MASTER_TIMEOUT_EN, POLL SHALL poll indefinitely and the counter SHALL not exist.

Structure
REQ-031 Package axi4_lite_pkg SHALL hold the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR), register-offset constants, and the master state enum.
REQ-032 A single-transaction engine sub-module, axi4_lite_master_port, SHALL own the AW/W/B/AR/R handshakes; the top holds the FSM.

Verification
REQ-033 a=3, b=5, slave always ready, STATUS ready on the 3rd poll -> writes 3, 5, 1; 3 STATUS reads; rsp_res=15, rsp_err=0.
REQ-034 a=b=0xFFFFFFFF -> rsp_res=0xFFFFFFFE00000001.
REQ-035 awready 4 cycles after wready, random arready/rvalid stalls -> addr/data held stable; same result as with no stalls.
REQ-036 bresp=SLVERR on the B write -> no CTRL write issued; rsp_err=1, rsp_res=0.
REQ-037 _rst asserted in POLL with arvalid=1 -> next cycle arvalid=0, cmd_ready=1 after release; the following command completes normally.
REQ-038 With AXI_MASTER_TIMEOUT_EN and POLL_MAX=4, STATUS stuck at 0 -> exactly 4 reads, then rsp_err=1.
